// File: rtl/adc_capture_buffer_pkg.sv
// Shared types and helpers for the ADC capture buffer: FSM states,
// frame word sizing and the saturating magnitude used by the trigger.
package adc_capture_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PRE,
    ST_ARMED,
    ST_POST,
    ST_DONE
  } cap_state_e;

  localparam int MAG_W = 32;

  function automatic int frame_width(input int num_channels, input int data_w);
    return num_channels * data_w;
  endfunction

  localparam int DEF_FRAME_W = frame_width(4, 16);

  // |x| for a data_w-bit value already sign-extended to MAG_W bits; the most
  // negative input clips to the largest positive value instead of wrapping.
  function automatic logic [MAG_W-1:0] sat_mag(input logic signed [MAG_W-1:0] x,
                                                input int data_w);
    logic [MAG_W-1:0] lim;
    logic [MAG_W-1:0] m;
    lim = (32'd1 << (data_w - 1)) - 32'd1;
    m   = x[MAG_W-1] ? 32'(-x) : 32'(x);
    return (m > lim) ? lim : m;
  endfunction

endpackage

// File: rtl/adc_capture_buffer_frame_ram.sv
// Simple dual-port frame store: one write port, one registered read port.
module frame_ram
  import adc_capture_pkg::*;
#(
  parameter int ADDR_W = 10,
  parameter int WIDTH  = 64
) (
  input  logic              clk,
  input  logic              wr_en_i,
  input  logic [ADDR_W-1:0] wr_addr_i,
  input  logic [WIDTH-1:0]  wr_data_i,
  input  logic              rd_en_i,
  input  logic [ADDR_W-1:0] rd_addr_i,
  output logic [WIDTH-1:0]  rd_data_o
);

  logic [WIDTH-1:0] mem_q [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (wr_en_i) mem_q[wr_addr_i] <= wr_data_i;
    if (rd_en_i) rd_data_o <= mem_q[rd_addr_i];
  end

endmodule

// File: rtl/adc_capture_buffer.sv
// Multi-channel capture buffer: aligns per-channel samples into frames, stores
// them circularly and freezes a pre/post window around the first trigger frame.
module adc_capture_buffer
  import adc_capture_pkg::*;
#(
  parameter int NUM_CHANNELS = 4,
  parameter int DATA_W       = 16,
  parameter int DEPTH        = 1024,
  parameter int ADDR_W       = $clog2(DEPTH),
  localparam int CH_W        = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [DATA_W-1:0]       in_data [NUM_CHANNELS],
  input  logic [NUM_CHANNELS-1:0] in_valid,
  input  logic                    arm,
  input  logic                    force_trig,
  input  logic [DATA_W-1:0]       threshold,
  input  logic [ADDR_W-1:0]       pre_trig,
  output logic                    busy,
  output logic                    done,
  output logic                    skew_err,
  output logic [ADDR_W-1:0]       trig_frame,
  input  logic                    rd_en,
  input  logic [ADDR_W-1:0]       rd_addr,
  input  logic [CH_W-1:0]         rd_ch,
  output logic [DATA_W-1:0]       rd_data,
  output logic                    rd_valid
);

  localparam int FRAME_W = frame_width(NUM_CHANNELS, DATA_W);
  localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W:0] CNT_ONE = (ADDR_W + 1)'(1);

  logic [NUM_CHANNELS-1:0] pend_q, pend_d, ch_hit;
  logic [FRAME_W-1:0]      frame_word;
  logic                    frame_done, skew_hit;
  logic                    skew_q, skew_d;

  generate
    for (genvar gi = 0; gi < NUM_CHANNELS; gi++) begin : g_ch
      logic [DATA_W-1:0] lat_q;
      logic [DATA_W-1:0] smp;

      assign smp = in_valid[gi] ? in_data[gi] : lat_q;
      assign frame_word[gi*DATA_W +: DATA_W] = smp;
      assign ch_hit[gi] = sat_mag(32'(signed'(smp)), DATA_W) >= 32'(threshold);

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)            lat_q <= '0;
        else if (in_valid[gi]) lat_q <= in_data[gi];
      end
    end
  endgenerate

  assign frame_done = &(pend_q | in_valid);
  assign skew_hit   = |(pend_q & in_valid);
  assign pend_d     = frame_done ? '0 : (pend_q | in_valid);
  assign skew_d     = (arm ? 1'b0 : skew_q) | skew_hit;

  cap_state_e        state_q, state_d, eff_state;
  logic [ADDR_W-1:0] ptr_q, ptr_d, eff_ptr;
  logic [ADDR_W:0]   cnt_q, cnt_d, eff_cnt, cnt_inc, post_len;
  logic [ADDR_W-1:0] pre_q, pre_d;
  logic [ADDR_W-1:0] trig_addr_q, trig_addr_d;
  logic              force_q, force_d, eff_force;
  logic              wr_en;

  // An arm in the same cycle as a completing frame makes that frame the
  // first of the new capture, so the frame is processed against the post-arm view.
  always_comb begin
    eff_state   = state_q;
    eff_ptr     = ptr_q;
    eff_cnt     = cnt_q;
    eff_force   = force_q;
    pre_d       = pre_q;
    trig_addr_d = trig_addr_q;
    wr_en       = 1'b0;
    if (arm) begin
      eff_state = (pre_trig == '0) ? ST_ARMED : ST_PRE;
      eff_ptr   = '0;
      eff_cnt   = '0;
      eff_force = 1'b0;
      pre_d     = pre_trig;
    end
    state_d  = eff_state;
    ptr_d    = eff_ptr;
    cnt_d    = eff_cnt;
    force_d  = eff_force;
    cnt_inc  = eff_cnt + CNT_ONE;
    post_len = DEPTH_C - {1'b0, pre_d};
    case (eff_state)
      ST_PRE: begin
        if (frame_done) begin
          wr_en = 1'b1;
          ptr_d = eff_ptr + 1'b1;
          cnt_d = cnt_inc;
          if (cnt_inc == {1'b0, pre_d}) begin
            state_d = ST_ARMED;
            cnt_d   = '0;
          end
        end
      end
      ST_ARMED: begin
        force_d = eff_force | force_trig;
        if (frame_done) begin
          wr_en = 1'b1;
          ptr_d = eff_ptr + 1'b1;
          if ((|ch_hit) || force_d) begin
            trig_addr_d = eff_ptr;
            cnt_d       = CNT_ONE;
            force_d     = 1'b0;
            state_d     = (post_len == CNT_ONE) ? ST_DONE : ST_POST;
          end
        end
      end
      ST_POST: begin
        if (frame_done) begin
          wr_en = 1'b1;
          ptr_d = eff_ptr + 1'b1;
          cnt_d = cnt_inc;
          if (cnt_inc == post_len) state_d = ST_DONE;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      ptr_q       <= '0;
      cnt_q       <= '0;
      pre_q       <= '0;
      trig_addr_q <= '0;
      force_q     <= 1'b0;
      pend_q      <= '0;
      skew_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      cnt_q       <= cnt_d;
      pre_q       <= pre_d;
      trig_addr_q <= trig_addr_d;
      force_q     <= force_d;
      pend_q      <= pend_d;
      skew_q      <= skew_d;
    end
  end

  assign busy       = (state_q == ST_PRE) || (state_q == ST_ARMED) || (state_q == ST_POST);
  assign done       = (state_q == ST_DONE);
  assign skew_err   = skew_q;
  assign trig_frame = pre_q;

  logic [ADDR_W-1:0]  rd_phys;
  logic [FRAME_W-1:0] rd_word;
  logic [DATA_W-1:0]  rd_lane [NUM_CHANNELS];
  logic               rd_v1_q, rd_valid_q;
  logic [CH_W-1:0]    rd_ch1_q;
  logic [DATA_W-1:0]  rd_data_q;

  // Window index 0 is the oldest retained frame, pre_q frames before the trigger.
  assign rd_phys = trig_addr_q - pre_q + rd_addr;

  frame_ram #(
    .ADDR_W (ADDR_W),
    .WIDTH  (FRAME_W)
  ) u_ram (
    .clk       (clk),
    .wr_en_i   (wr_en),
    .wr_addr_i (eff_ptr),
    .wr_data_i (frame_word),
    .rd_en_i   (rd_en),
    .rd_addr_i (rd_phys),
    .rd_data_o (rd_word)
  );

  generate
    for (genvar gi = 0; gi < NUM_CHANNELS; gi++) begin : g_lane
      assign rd_lane[gi] = rd_word[gi*DATA_W +: DATA_W];
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_v1_q    <= 1'b0;
      rd_ch1_q   <= '0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      rd_v1_q    <= rd_en;
      rd_ch1_q   <= rd_ch;
      rd_valid_q <= rd_v1_q;
      if (rd_v1_q) rd_data_q <= rd_lane[rd_ch1_q];
    end
  end

  assign rd_data  = rd_data_q;
  assign rd_valid = rd_valid_q;

endmodule

// File: tb/tb_adc_capture_buffer.sv
// Self-checking bench for adc_capture_buffer (4 channels, 16-bit, 16-frame buffer).
module tb_adc_capture_buffer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] in_data [4];
  logic [3:0]  in_valid = '0;
  logic        arm = 1'b0;
  logic        force_trig = 1'b0;
  logic [15:0] threshold = '0;
  logic [3:0]  pre_trig = '0;
  logic        busy, done, skew_err;
  logic [3:0]  trig_frame;
  logic        rd_en = 1'b0;
  logic [3:0]  rd_addr = '0;
  logic [1:0]  rd_ch = '0;
  logic [15:0] rd_data;
  logic        rd_valid;

  int vec_cnt = 0;
  int err_cnt = 0;

  typedef struct {
    logic [15:0] data;
    int          addr;
    int          ch;
  } rd_exp_t;
  rd_exp_t sb[$];

  typedef struct {
    int          ch;
    logic [15:0] smp;
    logic [15:0] thr;
    bit          trig;
  } mag_vec_t;
  mag_vec_t tbl[8];

  adc_capture_buffer #(
    .NUM_CHANNELS (4),
    .DATA_W       (16),
    .DEPTH        (16)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .arm        (arm),
    .force_trig (force_trig),
    .threshold  (threshold),
    .pre_trig   (pre_trig),
    .busy       (busy),
    .done       (done),
    .skew_err   (skew_err),
    .trig_frame (trig_frame),
    .rd_en      (rd_en),
    .rd_addr    (rd_addr),
    .rd_ch      (rd_ch),
    .rd_data    (rd_data),
    .rd_valid   (rd_valid)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0d want %0d", nm, act, exp);
    end
  endtask

  task automatic frame_all(input int v0, input int v1, input int v2, input int v3);
    in_data[0] = 16'(v0);
    in_data[1] = 16'(v1);
    in_data[2] = 16'(v2);
    in_data[3] = 16'(v3);
    in_valid = 4'hF;
    tick();
    in_valid = '0;
  endtask

  task automatic frame_one(input int ch, input logic [15:0] smp);
    for (int c = 0; c < 4; c++) in_data[c] = '0;
    in_data[ch] = smp;
    in_valid = 4'hF;
    tick();
    in_valid = '0;
  endtask

  task automatic skew_frame(input int k);
    for (int j = 0; j < 4; j++) begin
      for (int c = 0; c < 4; c++) begin
        in_valid[c] = (((c + k) % 4) == j);
        in_data[c]  = 16'(3000 + k * 10 + c);
      end
      tick();
    end
    in_valid = '0;
  endtask

  task automatic do_arm(input int pre, input logic [15:0] thr);
    pre_trig  = 4'(pre);
    threshold = thr;
    arm = 1'b1;
    tick();
    arm = 1'b0;
  endtask

  task automatic pulse_force();
    force_trig = 1'b1;
    tick();
    force_trig = 1'b0;
  endtask

  task automatic rd(input int a, input int c, input logic [15:0] e);
    rd_exp_t x;
    rd_en   = 1'b1;
    rd_addr = 4'(a);
    rd_ch   = 2'(c);
    x.data = e;
    x.addr = a;
    x.ch   = c;
    sb.push_back(x);
    tick();
  endtask

  task automatic drain();
    rd_en = 1'b0;
    repeat (4) tick();
    chk("rd_drain", sb.size(), 0);
  endtask

  always @(negedge clk) begin : mon
    rd_exp_t x;
    if (rd_valid) begin
      if (sb.size() == 0) begin
        vec_cnt++;
        err_cnt++;
        $display("FAIL rd_unexpected: got %0d want none", rd_data);
      end else begin
        x = sb.pop_front();
        $display("read win[%0d] ch%0d = %0d", x.addr, x.ch, rd_data);
        chk($sformatf("rd[%0d].ch%0d", x.addr, x.ch), rd_data, x.data);
      end
    end
  end

  initial begin
    tbl[0] = '{0, 16'h8000, 16'h7FFF, 1'b1};
    tbl[1] = '{1, 16'h8001, 16'h8000, 1'b0};
    tbl[2] = '{2, 16'h8000, 16'h8000, 1'b0};
    tbl[3] = '{3, 16'h7FFF, 16'h7FFF, 1'b1};
    tbl[4] = '{0, 16'hFF9C, 16'd100,  1'b1};
    tbl[5] = '{1, 16'd99,   16'd100,  1'b0};
    tbl[6] = '{2, 16'd0,    16'd0,    1'b1};
    tbl[7] = '{3, 16'hFF9B, 16'd100,  1'b1};
    for (int c = 0; c < 4; c++) in_data[c] = '0;

    tick();
    tick();
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_skew", skew_err, 0);
    chk("rst_trig_frame", trig_frame, 0);
    chk("rst_rd_data", rd_data, 0);
    chk("rst_rd_valid", rd_valid, 0);
    rst_n = 1'b1;
    tick();

    // Ramp capture: trigger at frame 10, window = frames 6..21.
    do_arm(4, 16'd1000);
    chk("ramp_busy_armed", busy, 1);
    for (int k = 0; k <= 21; k++) begin
      frame_all(100 * k, 100 * k, 100 * k, 100 * k);
      if (k == 20) chk("ramp_done_early", done, 0);
    end
    chk("ramp_done", done, 1);
    chk("ramp_busy_low", busy, 0);
    chk("ramp_trig_frame", trig_frame, 4);
    frame_all(9999, 9999, 9999, 9999);
    for (int i = 0; i < 16; i++) rd(i, i % 4, 16'(100 * (6 + i)));
    drain();
    $display("ramp capture checked");

    // Skewed channels; force in PRE ignored, force in ARMED triggers frame 14.
    do_arm(12, 16'hFFFF);
    for (int k = 0; k < 3; k++) skew_frame(k);
    pulse_force();
    for (int k = 3; k < 14; k++) skew_frame(k);
    pulse_force();
    for (int k = 14; k < 18; k++) begin
      skew_frame(k);
      if (k == 15) begin
        chk("skew_done_early", done, 0);
        chk("skew_busy_post", busy, 1);
      end
    end
    chk("skew_done", done, 1);
    chk("skew_err_clean", skew_err, 0);
    chk("skew_trig_frame", trig_frame, 12);
    for (int i = 0; i < 16; i++)
      for (int c = 0; c < 4; c++) rd(i, c, 16'(3000 + (2 + i) * 10 + c));
    drain();
    $display("skewed capture checked");

    // Repeated channel strobes; pre_trig=0 with threshold 0.
    do_arm(0, 16'd0);
    in_valid = 4'b0100; in_data[2] = 16'd111; tick();
    in_data[2] = 16'd222; tick();
    in_valid = 4'b1011; in_data[0] = 16'd10; in_data[1] = 16'd11; in_data[3] = 16'd13; tick();
    in_valid = '0;
    chk("skew_err_set", skew_err, 1);
    in_valid = 4'b0010; in_data[1] = 16'd333; tick();
    in_valid = '0;
    frame_all(20, 444, 22, 23);
    for (int k = 2; k < 16; k++) begin
      frame_all(k * 10, k * 10 + 1, k * 10 + 2, k * 10 + 3);
      if (k == 14) chk("dup_done_early", done, 0);
    end
    chk("dup_done", done, 1);
    chk("dup_trig_frame", trig_frame, 0);
    rd(0, 2, 16'd222);
    rd(0, 0, 16'd10);
    rd(1, 1, 16'd444);
    rd(15, 3, 16'd153);
    drain();

    // Re-arm mid-POST together with a completing frame.
    do_arm(2, 16'd500);
    chk("arm_clears_skew", skew_err, 0);
    for (int k = 0; k <= 8; k++) frame_all(100 * k, 100 * k, 100 * k, 100 * k);
    chk("old_post_busy", busy, 1);
    pre_trig = 4'd2; threshold = 16'd7300; arm = 1'b1;
    frame_all(7000, 7000, 7000, 7000);
    arm = 1'b0;
    chk("rearm_busy", busy, 1);
    chk("rearm_done", done, 0);
    for (int k = 1; k <= 16; k++) begin
      frame_all(7000 + 100 * k, 7000 + 100 * k, 7000 + 100 * k, 7000 + 100 * k);
      if (k == 15) chk("rearm_done_early", done, 0);
    end
    chk("rearm_done_final", done, 1);
    for (int i = 0; i < 16; i++) rd(i, i % 4, 16'(7000 + 100 * (1 + i)));
    drain();
    $display("re-arm capture checked");

    // Magnitude / threshold vectors.
    for (int v = 0; v < 8; v++) begin
      do_arm(0, tbl[v].thr);
      frame_one(tbl[v].ch, tbl[v].smp);
      for (int k = 0; k < 15; k++) frame_all(0, 0, 0, 0);
      $display("vec %0d ch%0d smp %h thr %h done=%0b", v, tbl[v].ch, tbl[v].smp, tbl[v].thr, done);
      chk($sformatf("mag%0d_done", v), done, 32'(tbl[v].trig));
      chk($sformatf("mag%0d_busy", v), busy, 32'(!tbl[v].trig));
      if (tbl[v].trig) begin
        rd(0, tbl[v].ch, tbl[v].smp);
        rd(0, (tbl[v].ch + 1) % 4, 16'd0);
        drain();
      end
    end

    // Asynchronous reset in the middle of POST.
    do_arm(4, 16'd1000);
    in_valid = 4'b0001; in_data[0] = 16'd5; tick();
    in_data[0] = 16'd6; tick();
    in_valid = 4'b1110; in_data[1] = '0; in_data[2] = '0; in_data[3] = '0; tick();
    in_valid = '0;
    chk("pre_rst_skew", skew_err, 1);
    for (int k = 1; k <= 12; k++) frame_all(100 * k, 100 * k, 100 * k, 100 * k);
    chk("pre_rst_busy", busy, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_busy", busy, 0);
    chk("arst_done", done, 0);
    chk("arst_skew", skew_err, 0);
    chk("arst_trig_frame", trig_frame, 0);
    chk("arst_rd_data", rd_data, 0);
    chk("arst_rd_valid", rd_valid, 0);
    tick();
    rst_n = 1'b1;
    tick();
    do_arm(0, 16'd0);
    for (int k = 0; k < 16; k++) begin
      frame_all(k * 4 + 1, k * 4 + 2, k * 4 + 3, k * 4 + 4);
      if (k == 14) chk("fresh_done_early", done, 0);
    end
    chk("fresh_done", done, 1);
    rd(0, 0, 16'd1);
    rd(15, 3, 16'd64);
    rd(7, 2, 16'd31);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
